// File: rtl/fsm16bit_ctrl.sv
// fsm16bit_ctrl: press-driven 16-bit register (add/sub/rotate/load).
// Ports: clock, reset (sync, active-low), enable, check, mode,
//   direction, value[3:0] in; count[WIDTH-1:0] out (registered).
module fsm16bit_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter logic [WIDTH-1:0] CHECK_VALUE = WIDTH'(16'h0F20)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             check,
  input  logic             mode,
  input  logic             direction,
  input  logic [3:0]       value,
  output logic [WIDTH-1:0] count
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] op_res;
  logic             armed;
  logic             armed_nxt;

  // armed blocks a press that is already held across reset release;
  // it becomes set once enable has been seen low.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      armed <= ~enable;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      armed <= armed_nxt;
    end
  end

  always_comb begin
    op_res = count;
    unique case (1'b1)
      !check:
        op_res = CHECK_VALUE;
      check && mode && direction:
        op_res = count + WIDTH'(value);
      check && mode && !direction:
        op_res = count - WIDTH'(value);
      check && !mode && direction:
        op_res = {count[WIDTH-2:0], count[WIDTH-1]};
      check && !mode && !direction:
        op_res = {count[0], count[WIDTH-1:1]};
      default:
        op_res = count;
    endcase
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    armed_nxt = armed | ~enable;
    unique case (state)
      IDLE: begin
        if (enable && armed) begin
          count_nxt = op_res;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fsm16bit_ctrl.sv
// tb_fsm16bit_ctrl: directed scoreboard bench for fsm16bit_ctrl.
// Expected values come from a behavioural model pushed to a queue.
module tb_fsm16bit_ctrl;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        check;
  logic        mode;
  logic        direction;
  logic [3:0]  value;
  logic [15:0] count;

  int checks = 0;
  int failures = 0;
  logic [15:0] model;
  logic [15:0] sb[$];

  fsm16bit_ctrl dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .check(check),
    .mode(mode),
    .direction(direction),
    .value(value),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] op(input logic [15:0] c);
    logic [15:0] r;
    if (!check) r = 16'd3872;
    else if (mode && direction) r = c + {12'b0, value};
    else if (mode) r = c - {12'b0, value};
    else if (direction) r = {c[14:0], c[15]};
    else r = {c[0], c[15:1]};
    return r;
  endfunction

  task automatic compare(input string tag);
    logic [15:0] exp;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty observed=%h", tag, count);
    end else begin
      exp = sb.pop_front();
      assert (count === exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, count, exp);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input string tag);
    model = op(model);
    sb.push_back(model);
    enable = 1'b1;
    cycle();
    compare(tag);
    enable = 1'b0;
    cycle();
  endtask

  task automatic set_ctl(input logic c, input logic m,
                         input logic d, input logic [3:0] v);
    check = c;
    mode = m;
    direction = d;
    value = v;
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b1;
    set_ctl(1'b1, 1'b1, 1'b1, 4'd1);
    model = 16'h0000;
    // 1: reset with enable high, then release while still held
    cycle();
    cycle();
    sb.push_back(model);
    compare("reset");
    reset = 1'b1;
    repeat (3) cycle();
    sb.push_back(model);
    compare("held_after_reset");
    enable = 1'b0;
    cycle();
    // 2: add / subtract
    repeat (4) press("add1");
    value = 4'd3;
    press("add3");
    direction = 1'b0;
    press("sub3_a");
    press("sub3_b");
    // 3: rotates with wrap
    set_ctl(1'b1, 1'b0, 1'b1, 4'd0);
    press("rol_a");
    press("rol_b");
    direction = 1'b0;
    repeat (3) press("ror");
    direction = 1'b1;
    press("rol_wrap");
    // 4: check load, long hold
    set_ctl(1'b0, 1'b1, 1'b1, 4'd5);
    model = op(model);
    sb.push_back(model);
    enable = 1'b1;
    cycle();
    compare("check_load");
    for (int i = 0; i < 10; i++) begin
      sb.push_back(model);
      cycle();
      compare("check_hold");
    end
    enable = 1'b0;
    cycle();
    // 5: arithmetic wrap from zero
    reset = 1'b0;
    cycle();
    model = 16'h0000;
    sb.push_back(model);
    compare("reset2");
    reset = 1'b1;
    set_ctl(1'b1, 1'b1, 1'b0, 4'd1);
    press("sub_wrap");
    set_ctl(1'b1, 1'b1, 1'b1, 4'd2);
    press("add_wrap");
    // 6: control changes in HOLD are ignored
    set_ctl(1'b1, 1'b1, 1'b1, 4'd4);
    model = op(model);
    sb.push_back(model);
    enable = 1'b1;
    cycle();
    compare("press_hold");
    set_ctl(1'b0, 1'b0, 1'b0, 4'd9);
    repeat (3) begin
      sb.push_back(model);
      cycle();
      compare("hold_ctl_chg");
    end
    enable = 1'b0;
    cycle();
    set_ctl(1'b1, 1'b0, 1'b1, 4'd9);
    press("after_hold_rol");
    value = 4'd0;
    mode = 1'b1;
    press("add_zero");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm16bit_ctrl.md
Name: fsm16bit_ctrl

Overview:
- 16-bit register whose value changes once per enable press (rising edge of enable), under control of mode/direction/check.
- Operations: add or subtract a 4-bit operand, rotate left or right by one bit, or load a fixed check constant.
- Used as a user-driven arithmetic/shift unit behind debounced push-button and switch inputs.
- The result is shown on count.

Parameters:
- WIDTH, 16, width of count. The spec is written for 16.
- CHECK_VALUE, 16'd3872 (16'h0F20), constant loaded into count by a check operation.

Ports:
- clock  input  1  system clock. All logic on the rising edge.
- reset  input  1  one clock; reset is synchronous and active-low. When 0 at a rising clock edge, the block resets.
- enable  input  1  operation request, level signal. One operation per 0->1 transition.
- check  input  1  active-low. 0 at the trigger edge selects the check/load operation.
- mode  input  1  1 = arithmetic, 0 = rotate.
- direction  input  1
  - Arithmetic: 1 = add, 0 = subtract.
  - Rotate: 1 = left, 0 = right.
- value  input  4  operand for arithmetic, zero-extended to 16 bits.
- count  output  16  current register value. Driven directly from the register.

Behaviour:
- Reset (reset==0 at a rising edge): count<=0, FSM state<=IDLE. Reset has priority over everything, including mid-press. After reset is released, a still-high enable does not trigger an operation until it goes low and then high again.
- FSM, two states:
  - IDLE: waiting for a press. If enable==1 at an edge: perform the operation and go to HOLD.
  - HOLD: waiting for release. Count holds. If enable==0 at an edge: go to IDLE. Otherwise stay in HOLD.
- Latency: count updates on the same rising edge where enable is first sampled high in IDLE. The new value is visible immediately after that edge.
- All controls are sampled on that trigger edge. Changes to controls at any other time have no effect.
- Operation select, in priority order:
  1. check==0: count<=CHECK_VALUE (3872). Mode, direction and value are ignored.
  2. mode==1, direction==1: count<=count+{12'b0,value}, modulo 2^16. 0xFFFF+1 wraps to 0x0000.
  3. mode==1, direction==0: count<=count-{12'b0,value}, modulo 2^16. 0x0000-1 wraps to 0xFFFF.
  4. mode==0, direction==1: rotate left, count<={count[14:0],count[15]}.
  5. mode==0, direction==0: rotate right, count<={count[0],count[15:1]}.
- Edge cases:
  - value==0 still counts as one operation (count unchanged, FSM goes to HOLD).
  - Holding enable high for many cycles gives exactly one operation.
  - No overflow or borrow flags.
- Outputs are registered only; there are no combinational paths from inputs to count.

Test Plan:
1. reset=0 for 2 cycles with enable high -> count==0. Release reset while enable is still high -> no operation until enable goes low then high.
2. check=1, mode=1, direction=1, value=1, four one-cycle enable pulses -> count 1,2,3,4. Then value=3, one pulse -> 7. Then direction=0, two pulses -> 4, 1.
3. mode=0, direction=1, two pulses from 1 -> 2, 4. Then direction=0, three pulses -> 2, 1, 0x8000. Then direction=1, one pulse -> 0x0001 (wrap both ways).
4. check=0, any mode, one pulse -> count==3872 (0x0F20). Hold enable high for 10 cycles -> count stays 3872.
5. Wrap: from 0x0000, mode=1, direction=0, value=1 -> 0xFFFF. Then direction=1, value=2 -> 0x0001.
6. Change mode/direction/value while in HOLD (enable high) -> count unchanged. Next press uses the values sampled at that press edge.
